sysctrl_port_bridge: RTL and testbench

SYSCTRL_PORT_BRIDGE -- requirements
Module: sysctrl_port_bridge

---
 rtl/sysctrl_port_bridge_pkg.sv | 36 +++
 rtl/sysctrl_byte_fifo.sv | 49 ++++
 rtl/sysctrl_port_bridge.sv | 138 +++++++++++++
 tb/tb_sysctrl_port_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysctrl_port_bridge_pkg.sv
// Shared constants and types for the MCU <-> UART port bridge.
package sysctrl_port_bridge_pkg;

  localparam int DEPTH_DEFAULT = 16;
  localparam int WD_LIMIT      = 1024;
  localparam int WD_W          = $clog2(WD_LIMIT);

  // port_status field LSB positions
  localparam int STAT_BR_LO  = 24;
  localparam int STAT_BR_MID = 16;
  localparam int STAT_BR_HI  = 8;
  localparam int STAT_STOP   = 6;
  localparam int STAT_PARITY = 4;
  localparam int STAT_DBITS  = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_t;

  function automatic logic [31:0] pack_status(input logic [23:0] bitrate,
                                              input logic [3:0]  databits,
                                              input logic [1:0]  parity,
                                              input logic [1:0]  stopbits);
    logic [31:0] s;
    s = '0;
    s[STAT_BR_LO  +: 8] = bitrate[7:0];
    s[STAT_BR_MID +: 8] = bitrate[15:8];
    s[STAT_BR_HI  +: 8] = bitrate[23:16];
    s[STAT_STOP   +: 2] = stopbits;
    s[STAT_PARITY +: 2] = parity;
    s[STAT_DBITS  +: 4] = databits;
    return s;
  endfunction

endpackage

// File: rtl/sysctrl_byte_fifo.sv
// Byte FIFO with power-of-two depth; push/pop are pre-qualified by the caller.
// Head byte reads combinationally (0 when empty); flush empties it in one cycle.
module sysctrl_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, push+pop writes the slot being vacated; the old head is read out this cycle.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= din;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/sysctrl_port_bridge.sv
// Bridges a core UART byte stream to an MCU strobe-style port through two byte FIFOs.
// Any line-setting change flushes both FIFOs one cycle later; status/avail outputs are registered.
module sysctrl_port_bridge
  import sysctrl_port_bridge_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] port_status,
  output logic [7:0]  port_out_available,
  input  logic        port_out_strobe,
  output logic [7:0]  port_out_data,
  output logic [7:0]  port_in_available,
  input  logic        port_in_strobe,
  input  logic [7:0]  port_in_data,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [23:0] cfg_bitrate,
  input  logic [3:0]  cfg_databits,
  input  logic [1:0]  cfg_parity,
  input  logic [1:0]  cfg_stopbits,
  output logic        tx_overrun,
  output logic        rx_overrun
);
  localparam int CW = $clog2(DEPTH) + 1;

  ctrl_state_t      state;
  logic [31:0]      cfg_now;
  logic [31:0]      cfg_prev;
  logic             flush;
  logic             run;

  logic [CW-1:0]    tx_cnt, rx_cnt, tx_cnt_next, rx_cnt_next;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic             rx_drop;
  logic [WD_W-1:0]  wd_cnt;
  logic             stall_d;

  assign cfg_now = {cfg_bitrate, cfg_databits, cfg_parity, cfg_stopbits};
  assign flush   = (state == ST_FLUSH);
  assign run     = !flush;

  // A same-cycle pop frees the slot, so a full FIFO still accepts a push then.
  assign tx_pop  = port_out_strobe && !tx_empty && run;
  assign tx_push = tx_valid && (!tx_full || tx_pop) && run;
  assign rx_pop  = rx_ready && !rx_empty && run;
  assign rx_push = port_in_strobe && (!rx_full || rx_pop) && run;
  assign rx_drop = port_in_strobe && run && !rx_push;

  assign tx_cnt_next = flush ? '0 : tx_cnt + CW'(tx_push) - CW'(tx_pop);
  assign rx_cnt_next = flush ? '0 : rx_cnt + CW'(rx_push) - CW'(rx_pop);

  assign rx_valid = !rx_empty;

  sysctrl_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (tx_data),
    .dout  (port_out_data),
    .count (tx_cnt),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sysctrl_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .din   (port_in_data),
    .dout  (rx_data),
    .count (rx_cnt),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      cfg_prev <= cfg_now;
    end else begin
      cfg_prev <= cfg_now;
      case (state)
        ST_RUN:   state <= (cfg_now != cfg_prev) ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state <= (cfg_now != cfg_prev) ? ST_FLUSH : ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // Registered from next-cycle counts so these always agree with the FIFO contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_status        <= '0;
      tx_ready           <= 1'b1;
      port_out_available <= 8'h00;
      port_in_available  <= 8'(DEPTH);
    end else begin
      port_status        <= pack_status(cfg_bitrate, cfg_databits, cfg_parity, cfg_stopbits);
      tx_ready           <= (tx_cnt_next < CW'(DEPTH));
      port_out_available <= 8'(tx_cnt_next);
      port_in_available  <= 8'(CW'(DEPTH) - rx_cnt_next);
    end
  end

  // Watchdog: the first stalled cycle only arms stall_d, so overrun fires on stall cycle WD_LIMIT+1.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tx_overrun <= 1'b0;
      rx_overrun <= 1'b0;
      wd_cnt     <= '0;
      stall_d    <= 1'b0;
    end else begin
      if (rx_drop) rx_overrun <= 1'b1;
      if (tx_push || !tx_valid) begin
        wd_cnt  <= '0;
        stall_d <= 1'b0;
      end else begin
        stall_d <= 1'b1;
        if (stall_d) begin
          if (wd_cnt == WD_W'(WD_LIMIT - 1)) tx_overrun <= 1'b1;
          else                               wd_cnt     <= wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysctrl_port_bridge.sv
// Directed + randomized bench for sysctrl_port_bridge against a queue-based reference model.
module tb_sysctrl_port_bridge;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] port_status;
  logic [7:0]  port_out_available;
  logic        port_out_strobe;
  logic [7:0]  port_out_data;
  logic [7:0]  port_in_available;
  logic        port_in_strobe;
  logic [7:0]  port_in_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [23:0] cfg_bitrate;
  logic [3:0]  cfg_databits;
  logic [1:0]  cfg_parity;
  logic [1:0]  cfg_stopbits;
  logic        tx_overrun;
  logic        rx_overrun;

  sysctrl_port_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .port_status(port_status),
    .port_out_available(port_out_available), .port_out_strobe(port_out_strobe),
    .port_out_data(port_out_data), .port_in_available(port_in_available),
    .port_in_strobe(port_in_strobe), .port_in_data(port_in_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cfg_bitrate(cfg_bitrate), .cfg_databits(cfg_databits),
    .cfg_parity(cfg_parity), .cfg_stopbits(cfg_stopbits),
    .tx_overrun(tx_overrun), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  q_tx[$];
  logic [7:0]  q_rx[$];
  bit          m_txov, m_rxov, m_flush;
  int          m_stall;
  logic [31:0] m_cfg_prev;
  logic [31:0] m_status;

  function automatic logic [31:0] cfg_cat();
    return {cfg_bitrate, cfg_databits, cfg_parity, cfg_stopbits};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  sz;
    bit  popped;
    if (reset) begin
      q_tx.delete(); q_rx.delete();
      m_txov = 0; m_rxov = 0; m_stall = 0; m_flush = 0;
      m_cfg_prev = cfg_cat();
      m_status = 32'h0;
      return;
    end
    m_status = {cfg_bitrate[7:0], cfg_bitrate[15:8], cfg_bitrate[23:16],
                cfg_stopbits, cfg_parity, cfg_databits};
    if (m_flush) begin
      q_tx.delete(); q_rx.delete();
      m_txov = 0; m_rxov = 0; m_stall = 0;
    end else begin
      sz = q_tx.size(); popped = 0;
      if (port_out_strobe && sz > 0) begin q_tx.delete(0); popped = 1; end
      if (tx_valid && (sz < DEPTH || popped)) begin
        q_tx.push_back(tx_data);
        m_stall = 0;
      end else if (tx_valid) begin
        m_stall++;
        if (m_stall > 1024) m_txov = 1;
      end else begin
        m_stall = 0;
      end
      sz = q_rx.size(); popped = 0;
      if (rx_ready && sz > 0) begin q_rx.delete(0); popped = 1; end
      if (port_in_strobe) begin
        if (sz < DEPTH || popped) q_rx.push_back(port_in_data);
        else m_rxov = 1;
      end
    end
    m_flush = (cfg_cat() != m_cfg_prev);
    m_cfg_prev = cfg_cat();
  endtask

  task automatic check_all();
    chk("out_avail", 32'(port_out_available), 32'(q_tx.size()));
    chk("out_data",  32'(port_out_data), (q_tx.size() > 0) ? 32'(q_tx[0]) : 32'h0);
    chk("tx_ready",  32'(tx_ready), 32'(q_tx.size() < DEPTH));
    chk("in_avail",  32'(port_in_available), 32'(DEPTH - q_rx.size()));
    chk("rx_valid",  32'(rx_valid), 32'(q_rx.size() > 0));
    chk("rx_data",   32'(rx_data), (q_rx.size() > 0) ? 32'(q_rx[0]) : 32'h0);
    chk("tx_ovr",    32'(tx_overrun), 32'(m_txov));
    chk("rx_ovr",    32'(rx_overrun), 32'(m_rxov));
    chk("status",    port_status, m_status);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    port_out_strobe = 0; port_in_strobe = 0; tx_valid = 0; rx_ready = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_avail"}, 32'(port_out_available), 32'h0);
    chk({tag, "_in_avail"},  32'(port_in_available), 32'(DEPTH));
    chk({tag, "_out_data"},  32'(port_out_data), 32'h0);
    chk({tag, "_tx_ready"},  32'(tx_ready), 32'h1);
    chk({tag, "_rx_valid"},  32'(rx_valid), 32'h0);
    chk({tag, "_rx_data"},   32'(rx_data), 32'h0);
    chk({tag, "_ovr"},       32'({tx_overrun, rx_overrun}), 32'h0);
    chk({tag, "_status"},    port_status, 32'h0);
  endtask

  initial begin
    int guard;
    cfg_bitrate = 24'h01C200; cfg_databits = 4'd8; cfg_parity = 2'd0; cfg_stopbits = 2'd1;
    port_in_data = 8'h00; tx_data = 8'h00;
    idle_inputs();

    // Reset with strobes active: they must be ignored.
    reset = 1; port_in_strobe = 1; tx_valid = 1; port_out_strobe = 1;
    step(); step();
    check_reset_values("reset0");
    reset = 0; idle_inputs();
    step();
    chk("status_115200_8n1", port_status, 32'h00C20148);

    // Three TX bytes in, three pops out.
    tx_valid = 1;
    for (int i = 0; i < 3; i++) begin tx_data = 8'h41 + 8'(i); step(); end
    tx_valid = 0;
    step();
    chk("tx3_avail", 32'(port_out_available), 32'd3);
    chk("tx3_head",  32'(port_out_data), 32'h41);
    port_out_strobe = 1;
    step(); chk("pop1_data", 32'(port_out_data), 32'h42);
    step(); chk("pop2_data", 32'(port_out_data), 32'h43);
    step(); chk("pop3_avail", 32'(port_out_available), 32'h0);
    chk("pop3_data", 32'(port_out_data), 32'h0);
    step(); chk("empty_pop_avail", 32'(port_out_available), 32'h0);
    port_out_strobe = 0;

    // 17 RX pushes with rx_ready low: the 17th drops.
    port_in_strobe = 1;
    for (int i = 0; i < 17; i++) begin port_in_data = 8'h10 + 8'(i); step(); end
    port_in_strobe = 0;
    chk("rx17_in_avail", 32'(port_in_available), 32'h0);
    chk("rx17_ovr", 32'(rx_overrun), 32'h1);
    chk("rx17_valid", 32'(rx_valid), 32'h1);
    rx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("rx_order", 32'(rx_data), 32'h10 + 32'(i));
      step();
    end
    chk("rx_drained_valid", 32'(rx_valid), 32'h0);
    chk("rx_ovr_sticky", 32'(rx_overrun), 32'h1);
    rx_ready = 0;

    // Fill TX, then push+pop in the same cycle while full.
    tx_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin tx_data = 8'h80 + 8'(i); step(); end
    chk("txfull_ready", 32'(tx_ready), 32'h0);
    tx_data = 8'hEE; port_out_strobe = 1;
    step();
    tx_valid = 0; port_out_strobe = 0;
    chk("full_pushpop_avail", 32'(port_out_available), 32'd16);
    chk("full_pushpop_head", 32'(port_out_data), 32'h81);
    port_out_strobe = 1;
    for (int i = 0; i < DEPTH - 1; i++) step();
    chk("full_pushpop_tail", 32'(port_out_data), 32'hEE);
    step();
    port_out_strobe = 0;

    // Queue 5 TX and 3 RX, then change bitrate -> flush.
    tx_valid = 1; port_in_strobe = 1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'($urandom); port_in_data = 8'($urandom);
      if (i == 3) port_in_strobe = 0;
      step();
    end
    idle_inputs();
    chk("preflush_tx", 32'(port_out_available), 32'd5);
    chk("preflush_rx", 32'(port_in_available), 32'd13);
    chk("preflush_rxovr", 32'(rx_overrun), 32'h1);
    cfg_bitrate = 24'h002580;
    step();
    chk("flush_pending_tx", 32'(port_out_available), 32'd5);
    step();
    chk("flush_tx", 32'(port_out_available), 32'h0);
    chk("flush_rx", 32'(port_in_available), 32'd16);
    chk("flush_ovr", 32'({tx_overrun, rx_overrun}), 32'h0);
    chk("status_9600", port_status, 32'h80250048);

    // Randomized traffic with occasional config changes and resets.
    for (int i = 0; i < 600; i++) begin
      int pop_pct;
      pop_pct = (i % 200 < 100) ? 20 : 75;
      reset           = ($urandom_range(0, 149) == 0);
      tx_valid        = ($urandom_range(0, 99) < 65);
      tx_data         = 8'($urandom);
      port_out_strobe = ($urandom_range(0, 99) < pop_pct);
      port_in_strobe  = ($urandom_range(0, 99) < 65);
      port_in_data    = 8'($urandom);
      rx_ready        = ($urandom_range(0, 99) < pop_pct);
      if ($urandom_range(0, 49) == 0) cfg_bitrate = 24'($urandom);
      if ($urandom_range(0, 79) == 0) cfg_parity = 2'($urandom);
      step();
    end
    reset = 0; idle_inputs();
    step(); step();

    // Stall watchdog: full TX with tx_valid held.
    tx_valid = 1;
    guard = 0;
    while (q_tx.size() < DEPTH && guard < 64) begin tx_data = 8'($urandom); step(); guard++; end
    chk("wd_fill_reached", 32'(port_out_available), 32'(DEPTH));
    for (int i = 0; i < 1024; i++) step();
    chk("wd_1024_no_ovr", 32'(tx_overrun), 32'h0);
    step();
    chk("wd_1025_ovr", 32'(tx_overrun), 32'h1);
    step();
    chk("wd_ovr_sticky", 32'(tx_overrun), 32'h1);

    reset = 1; port_out_strobe = 1; port_in_strobe = 1;
    step();
    check_reset_values("reset1");
    reset = 0; idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
